// File: rtl/jts16_scr_rom_resp_pkg.sv
// Shared S16 scroll ROM responder definitions: FSM encoding and client ids.
package jts16_scr_rom_resp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DATA = 2'd2
    } st_t;

    localparam logic ID_MAP = 1'b0;
    localparam logic ID_SCR = 1'b1;

    localparam int MAP_TW = 14;   // map_addr[15:2]
    localparam int SCR_TW = 16;   // scr_addr[17:2]

endpackage

// File: rtl/jts16_scr_rom_resp_if.sv
// SDRAM bank slot bus: request/grant handshake plus read-data return.
interface jts16_scr_rom_resp_if #(
    parameter int AW = 22
);
    logic          req;
    logic [AW-1:0] addr;
    logic          gnt;
    logic          rdy;
    logic [31:0]   din;

    modport master (output req, output addr, input gnt, input rdy, input din);
    modport slave  (input req, input addr, output gnt, output rdy, output din);
endinterface

// File: rtl/jts16_rom_tagbuf.sv
// One client's cached 32-bit word: tag, data and valid with a live hit compare.
module jts16_rom_tagbuf #(
    parameter int TW = 16
) (
    input  logic          rst,
    input  logic          clk,
    input  logic          wr,
    input  logic [TW-1:0] wr_tag,
    input  logic [31:0]   wr_data,
    input  logic [TW-1:0] rd_tag,
    output logic          hit,
    output logic [31:0]   data
);
    logic [TW-1:0] tag;
    logic [31:0]   dbuf;
    logic          vld;

    always_ff @(posedge clk, posedge rst) begin
        if (rst) begin
            tag  <= '0;
            dbuf <= '0;
            vld  <= 1'b0;
        end else if (wr) begin
            tag  <= wr_tag;
            dbuf <= wr_data;
            vld  <= 1'b1;
        end
    end

    // Combinational so the client sees ok drop the same cycle its address moves.
    assign hit  = vld && (tag == rd_tag);
    assign data = dbuf;
endmodule

// File: rtl/jts16_scr_rom_resp.sv
// Scroll-layer memory responder: serves tile map and tile graphics reads over one slot.
module jts16_scr_rom_resp
    import jts16_scr_rom_resp_pkg::*;
#(
    parameter int            AW         = 22,
    parameter logic [AW-1:0] MAP_OFFSET = 22'h0,
    parameter logic [AW-1:0] SCR_OFFSET = 22'h4000
) (
    input  logic                   rst,
    input  logic                   clk,
    input  logic [15:1]            map_addr,
    output logic [15:0]            map_data,
    output logic                   map_ok,
    input  logic [17:2]            scr_addr,
    output logic [31:0]            scr_data,
    output logic                   scr_ok,
    jts16_scr_rom_resp_if.master   mem
);
    st_t         st;
    logic [15:0] req_tag;
    logic        req_id;
    logic        last_id;
    logic [31:0] map_buf;
    logic        map_pend, scr_pend, pick_map;
    logic        map_wr, scr_wr;
    logic [AW-1:0] map_maddr, scr_maddr;

    assign map_pend = !map_ok;
    assign scr_pend = !scr_ok;
    // Round-robin: map goes when alone or when scr was served last.
    assign pick_map = map_pend && (!scr_pend || last_id == ID_SCR);

    assign map_maddr = MAP_OFFSET + AW'(map_addr[15:2]);
    assign scr_maddr = SCR_OFFSET + AW'(scr_addr);

    assign map_wr = (st == ST_DATA) && mem.rdy && (req_id == ID_MAP);
    assign scr_wr = (st == ST_DATA) && mem.rdy && (req_id == ID_SCR);

    jts16_rom_tagbuf #(.TW(MAP_TW)) u_map (
        .rst     (rst),
        .clk     (clk),
        .wr      (map_wr),
        .wr_tag  (req_tag[MAP_TW-1:0]),
        .wr_data (mem.din),
        .rd_tag  (map_addr[15:2]),
        .hit     (map_ok),
        .data    (map_buf)
    );

    jts16_rom_tagbuf #(.TW(SCR_TW)) u_scr (
        .rst     (rst),
        .clk     (clk),
        .wr      (scr_wr),
        .wr_tag  (req_tag),
        .wr_data (mem.din),
        .rd_tag  (scr_addr),
        .hit     (scr_ok),
        .data    (scr_data)
    );

    assign map_data = map_addr[1] ? map_buf[31:16] : map_buf[15:0];

    // Requests are never aborted; data always lands under the tag latched at issue.
    always_ff @(posedge clk, posedge rst) begin
        if (rst) begin
            st       <= ST_IDLE;
            mem.req  <= 1'b0;
            mem.addr <= '0;
            req_tag  <= '0;
            req_id   <= ID_MAP;
            last_id  <= ID_SCR;
        end else begin
            case (st)
                ST_IDLE: if (map_pend || scr_pend) begin
                    mem.req  <= 1'b1;
                    mem.addr <= pick_map ? map_maddr : scr_maddr;
                    req_tag  <= pick_map ? {2'b00, map_addr[15:2]} : scr_addr;
                    req_id   <= pick_map ? ID_MAP : ID_SCR;
                    st       <= ST_REQ;
                end
                ST_REQ: if (mem.gnt) begin
                    mem.req <= 1'b0;
                    st      <= ST_DATA;
                end
                ST_DATA: if (mem.rdy) begin
                    last_id <= req_id;
                    st      <= ST_IDLE;
                end
                default: st <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_jts16_scr_rom_resp.sv
// Directed bench for jts16_scr_rom_resp with a hand-driven memory slot.
module tb_jts16_scr_rom_resp;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:1] map_addr;
    logic [15:0] map_data;
    logic        map_ok;
    logic [17:2] scr_addr;
    logic [31:0] scr_data;
    logic        scr_ok;
    int          checks = 0;
    int          errors = 0;

    jts16_scr_rom_resp_if #(.AW(22)) mem_if();

    jts16_scr_rom_resp dut (
        .rst      (rst),
        .clk      (clk),
        .map_addr (map_addr),
        .map_data (map_data),
        .map_ok   (map_ok),
        .scr_addr (scr_addr),
        .scr_data (scr_data),
        .scr_ok   (scr_ok),
        .mem      (mem_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Renderer-side halfword address; the port drops bit 0.
    task automatic set_map(input logic [15:0] a);
        map_addr = a[15:1];
    endtask

    task automatic wait_req(input string tag, input logic [21:0] exp);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mem_if.req && n < 50);
        if (!mem_if.req) chk({tag, "_timeout"}, 32'd0, 32'd1);
        else chk({tag, "_addr"}, 32'(mem_if.addr), 32'(exp));
    endtask

    task automatic do_gnt;
        mem_if.gnt = 1'b1;
        @(negedge clk);
        mem_if.gnt = 1'b0;
        chk("req_drop", 32'(mem_if.req), 32'd0);
    endtask

    task automatic do_rdy(input logic [31:0] d);
        mem_if.rdy = 1'b1;
        mem_if.din = d;
        @(negedge clk);
        mem_if.rdy = 1'b0;
    endtask

    task automatic no_req(input int n);
        repeat (n) begin
            @(negedge clk);
            chk("no_req", 32'(mem_if.req), 32'd0);
        end
    endtask

    initial begin
        rst = 1'b1;
        mem_if.gnt = 1'b0;
        mem_if.rdy = 1'b0;
        mem_if.din = '0;
        set_map(16'h0010);
        scr_addr = '0;
        repeat (3) @(negedge clk);
        chk("rst_map_ok", 32'(map_ok), 32'd0);
        chk("rst_scr_ok", 32'(scr_ok), 32'd0);
        chk("rst_req", 32'(mem_if.req), 32'd0);
        chk("rst_addr", 32'(mem_if.addr), 32'd0);
        chk("rst_map_data", 32'(map_data), 32'd0);
        chk("rst_scr_data", scr_data, 32'd0);
        rst = 1'b0;

        // First fetch goes to map (word 4), then scr (word 0 of graphics)
        wait_req("t1_map", 22'h4);
        chk("t1_map_ok_miss", 32'(map_ok), 32'd0);
        do_gnt;
        repeat (2) @(negedge clk);
        do_rdy(32'hBEEF_1234);
        chk("t1_map_ok", 32'(map_ok), 32'd1);
        chk("t1_map_lo", 32'(map_data), 32'h1234);
        wait_req("t1_scr", 22'h4000);
        do_gnt;
        repeat (2) @(negedge clk);
        do_rdy(32'h0BAD_F00D);
        chk("t1_scr_ok", 32'(scr_ok), 32'd1);
        chk("t1_scr_data", scr_data, 32'h0BAD_F00D);

        // Halfword select within the cached word is a hit
        set_map(16'h0012);
        #1;
        chk("t2_map_ok", 32'(map_ok), 32'd1);
        chk("t2_map_hi", 32'(map_data), 32'hBEEF);
        no_req(4);

        // Both miss repeatedly: grants alternate
        set_map(16'h0100);
        scr_addr = 16'h0020;
        wait_req("t3_map0", 22'h40);
        do_gnt;
        do_rdy(32'h1111_2222);
        set_map(16'h0200);
        wait_req("t3_scr0", 22'h4020);
        do_gnt;
        do_rdy(32'h3333_4444);
        scr_addr = 16'h0030;
        wait_req("t3_map1", 22'h80);
        do_gnt;
        do_rdy(32'h5555_6666);
        wait_req("t3_scr1", 22'h4030);
        do_gnt;
        do_rdy(32'h7777_8888);
        chk("t3_map_ok", 32'(map_ok), 32'd1);
        chk("t3_map_data", 32'(map_data), 32'h6666);
        chk("t3_scr_ok", 32'(scr_ok), 32'd1);
        chk("t3_scr_data", scr_data, 32'h7777_8888);

        // scr address moves 5 -> 6 while its fetch is in flight
        scr_addr = 16'h0005;
        wait_req("t4_scr5", 22'h4005);
        do_gnt;
        scr_addr = 16'h0006;
        @(negedge clk);
        do_rdy(32'hC0DE_4005);
        chk("t4_scr_ok_stale", 32'(scr_ok), 32'd0);
        wait_req("t4_scr6", 22'h4006);
        do_gnt;
        scr_addr = 16'h0005;
        #1;
        chk("t4_back_ok", 32'(scr_ok), 32'd1);
        chk("t4_back_data", scr_data, 32'hC0DE_4005);
        scr_addr = 16'h0006;
        #1;
        chk("t4_fwd_ok", 32'(scr_ok), 32'd0);
        @(negedge clk);
        do_rdy(32'hC0DE_4006);
        chk("t4_scr_ok", 32'(scr_ok), 32'd1);
        chk("t4_scr_data", scr_data, 32'hC0DE_4006);

        // Grant withheld for 20 cycles; request issued one cycle after the miss
        set_map(16'h0300);
        @(negedge clk);
        chk("t5_lat_req", 32'(mem_if.req), 32'd1);
        chk("t5_lat_addr", 32'(mem_if.addr), 32'hC0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("t5_req_hold", 32'(mem_if.req), 32'd1);
            chk("t5_addr_hold", 32'(mem_if.addr), 32'hC0);
            chk("t5_ok_low", 32'({map_ok, scr_ok}), 32'b01);
        end
        do_gnt;
        @(negedge clk);
        do_rdy(32'hCAFE_0300);
        chk("t5_map_ok", 32'(map_ok), 32'd1);
        chk("t5_map_data", 32'(map_data), 32'h0300);

        // Reset in DATA, then late rdy pulses
        scr_addr = 16'h0040;
        wait_req("t6_scr", 22'h4040);
        do_gnt;
        rst = 1'b1;
        @(negedge clk);
        chk("t6_map_ok", 32'(map_ok), 32'd0);
        chk("t6_scr_ok", 32'(scr_ok), 32'd0);
        chk("t6_req", 32'(mem_if.req), 32'd0);
        chk("t6_map_data", 32'(map_data), 32'd0);
        chk("t6_scr_data", scr_data, 32'd0);
        do_rdy(32'hDEAD_DEAD);
        rst = 1'b0;
        do_rdy(32'hDEAD_BEEF);
        chk("t6_stray_map_ok", 32'(map_ok), 32'd0);
        chk("t6_stray_scr_ok", 32'(scr_ok), 32'd0);
        chk("t6_fresh_req", 32'(mem_if.req), 32'd1);
        wait_req("t6_map", 22'hC0);
        do_gnt;
        do_rdy(32'hCAFE_0300);
        chk("t6_map_ok2", 32'(map_ok), 32'd1);
        wait_req("t6_scr2", 22'h4040);
        do_gnt;
        do_rdy(32'h1234_5678);
        chk("t6_scr_ok2", 32'(scr_ok), 32'd1);
        chk("t6_scr_data2", scr_data, 32'h1234_5678);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end
endmodule
